alu_arbiter: RTL and testbench

- Shares the single 32-bit combinational ALU between two requesters: requester 0 (main datapath) and requester 1 (address/branch-compare unit).
- Each requester presents a, b and a 3-bit ALU control code under a req/ack handshake.
- The arbiter grants one request at a time, drives the ALU for one cycle and registers sum/zero/negative.
- It returns the registered result to the granted requester with a one-cycle ack pulse.

---
 rtl/alu_arbiter.sv | 176 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one external 32-bit combinational ALU between two requesters
//   (0 = main datapath, 1 = address/branch-compare unit). A grant latches the
//   chosen operands, drives the ALU for one cycle and registers the result.
//   The result then goes back to the granted requester with a one-cycle ack.
//   Sequence per operation: IDLE (sample/grant) -> EXEC -> RESP (ack).
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   req0/a0/b0/gin0        requester 0 request, operands, ALU control code
//   req1/a1/b1/gin1        requester 1 request, operands, ALU control code
//   ack0, ack1             one-cycle completion pulse per requester
//   res, res_z, res_n      registered ALU sum / zero / negative
//   res_err                last completed operation used an illegal code
//   busy                   high while in EXEC or RESP
//   alu_a, alu_b, alu_gin  registered drive to the ALU
//   alu_sum, alu_zout,
//   alu_nout               combinational ALU results
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH       = 32,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [2:0]       gin0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [2:0]       gin1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] res,
  output logic             res_z,
  output logic             res_n,
  output logic             res_err,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_gin,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic             alu_zout,
  input  logic             alu_nout
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t state_r;
  state_t state_nxt_s;
  logic   ptr_r;      // requester favoured when both ask (round-robin only)
  logic   gnt_r;      // id of the operation in flight
  logic   grant_s;    // a grant happens at the coming edge
  logic   gnt_id_s;   // which requester gets it

  // Control codes the ALU implements: add, sub, slt, and, or, sllv.
  function automatic logic gin_legal(input logic [2:0] g);
    case (g)
      3'b010, 3'b110, 3'b111, 3'b000, 3'b001, 3'b011: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  // Next-state and grant decision.
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    gnt_id_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req0 && req1) begin
          grant_s     = 1'b1;
          // Fixed priority hands every tie to requester 0.
          if (ROUND_ROBIN) begin
            gnt_id_s = ptr_r;
          end else begin
            gnt_id_s = 1'b0;
          end
          state_nxt_s = EXEC;
        end else if (req0) begin
          grant_s     = 1'b1;
          gnt_id_s    = 1'b0;
          state_nxt_s = EXEC;
        end else if (req1) begin
          grant_s     = 1'b1;
          gnt_id_s    = 1'b1;
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC:    state_nxt_s = RESP;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand latch, result capture, ack pulse, priority pointer and busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r   <= 1'b0;
      gnt_r   <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      res     <= {WIDTH{1'b0}};
      res_z   <= 1'b0;
      res_n   <= 1'b0;
      res_err <= 1'b0;
      busy    <= 1'b0;
      alu_a   <= {WIDTH{1'b0}};
      alu_b   <= {WIDTH{1'b0}};
      alu_gin <= 3'b010;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      // busy tracks the state being entered so it is high exactly in EXEC/RESP.
      busy <= (state_nxt_s != IDLE);
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            // Operands are frozen here; requester changes after this are ignored.
            gnt_r   <= gnt_id_s;
            alu_a   <= gnt_id_s ? a1   : a0;
            alu_b   <= gnt_id_s ? b1   : b0;
            alu_gin <= gnt_id_s ? gin1 : gin0;
          end else begin
            gnt_r <= gnt_r;
          end
        end
        EXEC: begin
          if (gin_legal(alu_gin)) begin
            res     <= alu_sum;
            res_z   <= alu_zout;
            res_n   <= alu_nout;
            res_err <= 1'b0;
          end else begin
            // ALU output is undefined for these codes; report a clean zero.
            res     <= {WIDTH{1'b0}};
            res_z   <= 1'b1;
            res_n   <= 1'b0;
            res_err <= 1'b1;
          end
          ack0 <= ~gnt_r;
          ack1 <= gnt_r;
        end
        RESP: begin
          if (ROUND_ROBIN) begin
            ptr_r <= ~gnt_r;
          end else begin
            ptr_r <= 1'b0;
          end
        end
        default: begin
          ptr_r <= ptr_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed bench for alu_arbiter. Two instances share the same stimulus:
//   u_rr (round-robin) and u_fp (fixed priority). Each has its own behavioural
//   ALU. Illegal codes make the ALU return 0xDEADBEEF, so a result that leaked
//   through would be visible.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [31:0] a0, b0, a1, b1;
  logic [2:0]  gin0, gin1;

  logic        ack0_rr, ack1_rr, z_rr, n_rr, err_rr, busy_rr;
  logic [31:0] res_rr, alu_a_rr, alu_b_rr, alu_sum_rr;
  logic [2:0]  alu_gin_rr;
  logic        alu_zout_rr, alu_nout_rr;

  logic        ack0_fp, ack1_fp, z_fp, n_fp, err_fp, busy_fp;
  logic [31:0] res_fp, alu_a_fp, alu_b_fp, alu_sum_fp;
  logic [2:0]  alu_gin_fp;
  logic        alu_zout_fp, alu_nout_fp;

  int n_err    = 0;
  int n_checks = 0;
  logic both_ack_seen = 1'b0;

  always #5 clk = ~clk;

  // Reference ALU.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] g);
    logic [31:0] d;
    d = a - b;
    case (g)
      3'b010:  return a + b;
      3'b110:  return d;
      3'b111:  return {31'd0, d[31]};
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b011:  return b << a[4:0];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_sum_rr  = alu_f(alu_a_rr, alu_b_rr, alu_gin_rr);
  assign alu_zout_rr = (alu_sum_rr == 32'd0);
  assign alu_nout_rr = alu_sum_rr[31];
  assign alu_sum_fp  = alu_f(alu_a_fp, alu_b_fp, alu_gin_fp);
  assign alu_zout_fp = (alu_sum_fp == 32'd0);
  assign alu_nout_fp = alu_sum_fp[31];

  alu_arbiter #(.WIDTH(32), .ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .gin0(gin0),
    .req1(req1), .a1(a1), .b1(b1), .gin1(gin1),
    .ack0(ack0_rr), .ack1(ack1_rr), .res(res_rr), .res_z(z_rr), .res_n(n_rr),
    .res_err(err_rr), .busy(busy_rr),
    .alu_a(alu_a_rr), .alu_b(alu_b_rr), .alu_gin(alu_gin_rr),
    .alu_sum(alu_sum_rr), .alu_zout(alu_zout_rr), .alu_nout(alu_nout_rr)
  );

  alu_arbiter #(.WIDTH(32), .ROUND_ROBIN(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .gin0(gin0),
    .req1(req1), .a1(a1), .b1(b1), .gin1(gin1),
    .ack0(ack0_fp), .ack1(ack1_fp), .res(res_fp), .res_z(z_fp), .res_n(n_fp),
    .res_err(err_fp), .busy(busy_fp),
    .alu_a(alu_a_fp), .alu_b(alu_b_fp), .alu_gin(alu_gin_fp),
    .alu_sum(alu_sum_fp), .alu_zout(alu_zout_fp), .alu_nout(alu_nout_fp)
  );

  // Sticky flag: the two acks of one instance must never be high together.
  always @(negedge clk) begin
    if ((ack0_rr && ack1_rr) || (ack0_fp && ack1_fp)) begin
      both_ack_seen = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request on the round-robin instance and wait (bounded) for its ack.
  // lat counts edges from the first sampling edge to the one after which ack is seen.
  task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] g, output int lat, output logic ok,
                        output logic other, output logic busy_exec);
    @(negedge clk);
    if (id == 0) begin
      req0 = 1'b1; a0 = a; b0 = b; gin0 = g;
    end else begin
      req1 = 1'b1; a1 = a; b1 = b; gin1 = g;
    end
    lat = 0; ok = 1'b0; other = 1'b0; busy_exec = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) busy_exec = busy_rr;
      if ((id == 0 && ack1_rr) || (id == 1 && ack0_rr)) other = 1'b1;
      if ((id == 0 && ack0_rr) || (id == 1 && ack1_rr)) begin
        ok = 1'b1;
        break;
      end
    end
    // Drop req on the edge following ack.
    @(posedge clk); #1;
    if (id == 0) req0 = 1'b0;
    else         req1 = 1'b0;
  endtask

  task automatic op(input string tag, input int id, input logic [31:0] a,
                    input logic [31:0] b, input logic [2:0] g, input logic [31:0] er,
                    input logic ez, input logic en, input logic ee);
    int   lat;
    logic ok, other, bx;
    run_op(id, a, b, g, lat, ok, other, bx);
    chk({tag, "_ack"},   {31'd0, ok},    32'd1);
    chk({tag, "_lat"},   lat,            32'd2);
    chk({tag, "_other"}, {31'd0, other}, 32'd0);
    chk({tag, "_busyx"}, {31'd0, bx},    32'd1);
    chk({tag, "_idle"},  {31'd0, busy_rr}, 32'd0);
    chk({tag, "_res"},   res_rr,         er);
    chk({tag, "_z"},     {31'd0, z_rr},  {31'd0, ez});
    chk({tag, "_n"},     {31'd0, n_rr},  {31'd0, en});
    chk({tag, "_err"},   {31'd0, err_rr}, {31'd0, ee});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int k, fp0, fp1, lat;
    logic ok;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
    gin0 = 3'b010; gin1 = 3'b010;
    repeat (3) @(posedge clk);
    #1;
    // Reset values
    chk("rst_ack0",  {31'd0, ack0_rr}, 32'd0);
    chk("rst_ack1",  {31'd0, ack1_rr}, 32'd0);
    chk("rst_res",   res_rr,           32'd0);
    chk("rst_flags", {29'd0, z_rr, n_rr, err_rr}, 32'd0);
    chk("rst_busy",  {31'd0, busy_rr}, 32'd0);
    chk("rst_alua",  alu_a_rr,         32'd0);
    chk("rst_alugin", {29'd0, alu_gin_rr}, 32'd2);
    rst_n = 1'b1;

    // Basic add / sub on each requester
    op("add0",  0, 32'd5, 32'd7, 3'b010, 32'd12, 1'b0, 1'b0, 1'b0);
    op("sub1z", 1, 32'd3, 32'd3, 3'b110, 32'd0,  1'b1, 1'b0, 1'b0);
    op("sub1n", 1, 32'd0, 32'd1, 3'b110, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);

    // Illegal code, then legal slt (-1 < 1, and 7 < 3 false)
    op("ill0",  0, 32'd1, 32'd2, 3'b100, 32'd0, 1'b1, 1'b0, 1'b1);
    op("slt1",  0, 32'hFFFF_FFFF, 32'd1, 3'b111, 32'd1, 1'b0, 1'b0, 1'b0);
    op("slt0",  1, 32'd7, 32'd3, 3'b111, 32'd0, 1'b1, 1'b0, 1'b0);

    // Operand change during EXEC must not affect the operation
    @(negedge clk);
    req0 = 1'b1; a0 = 32'd5; b0 = 32'd7; gin0 = 3'b010;
    @(posedge clk); #1;
    a0 = 32'd9;
    chk("late_busy", {31'd0, busy_rr}, 32'd1);
    @(posedge clk); #1;
    chk("late_ack", {31'd0, ack0_rr}, 32'd1);
    chk("late_res", res_rr, 32'd12);
    @(posedge clk); #1;
    req0 = 1'b0;
    op("sllv", 0, 32'd4, 32'd1, 3'b011, 32'd16, 1'b0, 1'b0, 1'b0);
    op("and",  1, 32'h0000_F0F0, 32'h0000_0FF0, 3'b000, 32'h0000_00F0, 1'b0, 1'b0, 1'b0);
    op("or",   0, 32'h0000_F0F0, 32'h0000_0FF0, 3'b001, 32'h0000_FFF0, 1'b0, 1'b0, 1'b0);

    // Reset during EXEC aborts; held req is re-granted afterwards
    @(negedge clk);
    req0 = 1'b1; a0 = 32'd1; b0 = 32'd2; gin0 = 3'b010;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_ack",  {30'd0, ack0_rr, ack1_rr}, 32'd0);
    chk("mrst_busy", {31'd0, busy_rr}, 32'd0);
    chk("mrst_res",  res_rr, 32'd0);
    chk("mrst_gin",  {29'd0, alu_gin_rr}, 32'd2);
    @(posedge clk); #1;
    chk("mrst_ack2", {30'd0, ack0_rr, ack1_rr}, 32'd0);
    rst_n = 1'b1;
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ack0_rr) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mrst_reack", {31'd0, ok}, 32'd1);
    chk("mrst_lat",   lat, 32'd2);
    chk("mrst_res2",  res_rr, 32'd3);
    @(posedge clk); #1;
    req0 = 1'b0;

    // Both requesters held for four operations
    do_reset();
    @(negedge clk);
    req0 = 1'b1; a0 = 32'd1;  b0 = 32'd1;  gin0 = 3'b010;
    req1 = 1'b1; a1 = 32'd10; b1 = 32'd20; gin1 = 3'b010;
    k = 0; fp0 = 0; fp1 = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (ack0_rr || ack1_rr) begin
        chk("rr_cycle", c, 2 + 3 * k);
        chk("rr_id", {31'd0, ack1_rr}, k % 2);
        chk("rr_res", res_rr, (k % 2 == 0) ? 32'd2 : 32'd30);
        k++;
      end
      if (ack1_fp) fp1++;
      if (ack0_fp) begin
        chk("fp_cycle", c, 2 + 3 * fp0);
        chk("fp_res", res_fp, 32'd2);
        fp0++;
      end
    end
    chk("rr_count",  k,   32'd4);
    chk("fp_count0", fp0, 32'd4);
    chk("fp_count1", fp1, 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("ack_excl", {31'd0, both_ack_seen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
